mem_rgb_stream: RTL

Synthesizable, parametrised successor to the behavioural RGB file memory. It captures one frame of NCH-channel pixels over a valid/ready write port into on-chip RAM. It then streams the frame out in either raster order or BLK x BLK block order, which feeds the 8x8 DCT/compression front end. It raises a per-block strobe (finish_64) and an end-of-frame strobe (finish).

---
 rtl/mem_rgb_pkg.sv | 18 +
 rtl/mem_rgb_addr_gen.sv | 83 ++++++++
 rtl/mem_rgb_stream.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_rgb_pkg.sv
// Shared types and constants for the RGB frame store/streamer.
// Covers the FSM state encoding, the readout mode values and the packed pixel width.
package mem_rgb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_t;

  localparam logic MODE_RASTER = 1'b0;
  localparam logic MODE_BLOCK  = 1'b1;

  function automatic int pix_width(input int nch, input int dw);
    return nch * dw;
  endfunction

endpackage

// File: rtl/mem_rgb_addr_gen.sv
// Read address sequencer: raster index or BLK x BLK block walk.
// Block addresses are built from accumulated bases, so no multiplier is needed per pixel.
module mem_rgb_addr_gen
  import mem_rgb_pkg::*;
#(
  parameter int AW  = 20,
  parameter int BLK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_advance,
  input  logic          i_mode,
  input  logic [15:0]   i_size_x,
  input  logic [AW:0]   i_npix,
  output logic [AW-1:0] o_addr,
  output logic [AW:0]   o_cnt,
  output logic          o_last_in_block,
  output logic          o_last_in_frame
);
  localparam int LB = $clog2(BLK);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   r_cnt;
  logic [LB-1:0] r_px;
  logic [LB-1:0] r_py;
  logic [AW-1:0] r_col_base;
  logic [AW-1:0] r_row_off;
  logic [AW-1:0] r_blk_row;
  logic [AW-1:0] w_size_x;
  logic [AW-1:0] w_col_next;
  logic [AW-1:0] w_blk_addr;
  logic          w_raster_blk_end;

  assign w_size_x         = AW'(i_size_x);
  assign w_col_next       = r_col_base + AW'(BLK);
  assign w_blk_addr       = r_blk_row + r_row_off + r_col_base + AW'(r_px);
  assign w_raster_blk_end = &r_cnt[2*LB-1:0];

  assign o_addr          = (i_mode == MODE_BLOCK) ? w_blk_addr : r_cnt[AW-1:0];
  assign o_cnt           = r_cnt;
  assign o_last_in_frame = (r_cnt == (i_npix - CNT_ONE));
  assign o_last_in_block = (i_mode == MODE_BLOCK) ? ((&r_px) && (&r_py))
                                                  : (w_raster_blk_end || o_last_in_frame);

  // Walk px, then py, then block column, then block row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_col_base <= '0;
      r_row_off  <= '0;
      r_blk_row  <= '0;
    end else if (i_clear) begin
      r_cnt      <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_col_base <= '0;
      r_row_off  <= '0;
      r_blk_row  <= '0;
    end else if (i_advance) begin
      r_cnt <= r_cnt + CNT_ONE;
      r_px  <= r_px + LB'(1);
      if (&r_px) begin
        if (&r_py) begin
          r_py      <= '0;
          r_row_off <= '0;
          if (w_col_next < w_size_x) begin
            r_col_base <= w_col_next;
          end else begin
            r_col_base <= '0;
            r_blk_row  <= r_blk_row + (w_size_x << LB);
          end
        end else begin
          r_py      <= r_py + LB'(1);
          r_row_off <= r_row_off + w_size_x;
        end
      end
    end
  end

endmodule

// File: rtl/mem_rgb_stream.sv
// One-frame pixel store: loads a frame over a valid/ready port into on-chip RAM,
// then streams it back in raster or block order with per-block and end-of-frame strobes.
module mem_rgb_stream
  import mem_rgb_pkg::*;
#(
  parameter int DW  = 8,
  parameter int NCH = 3,
  parameter int AW  = 20,
  parameter int BLK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       size_x,
  input  logic [15:0]       size_y,
  input  logic              mode,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [NCH*DW-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [NCH*DW-1:0] rd_data,
  output logic              finish_64,
  output logic              finish,
  output logic              busy,
  output logic              err
);
  localparam int PW = pix_width(NCH, DW);
  localparam int LB = $clog2(BLK);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_size_x;
  logic          r_mode;
  logic [AW:0]   r_npix;
  logic [AW:0]   r_wr_cnt;
  logic          r_rd_valid;
  logic [PW-1:0] r_rd_data;
  logic          r_finish_64;
  logic          r_finish;
  logic          r_err;
  logic [PW-1:0] r_mem [0:(1<<AW)-1];

  logic [31:0]   w_prod;
  logic          w_cfg_bad;
  logic          w_accept;
  logic          w_reject;
  logic          w_wr_en;
  logic          w_last_wr;
  logic          w_issue;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_ram_addr;
  logic [AW:0]   w_rd_cnt;
  logic          w_last_in_block;
  logic          w_last_in_frame;

  // 32-bit product so frames larger than the RAM are caught before latching N.
  assign w_prod    = {16'd0, size_x} * {16'd0, size_y};
  assign w_cfg_bad = (w_prod == 32'd0) || (w_prod > (32'd1 << AW)) ||
                     ((mode == MODE_BLOCK) && ((|size_x[LB-1:0]) || (|size_y[LB-1:0])));
  assign w_accept  = (r_state == IDLE) && start && !w_cfg_bad;
  assign w_reject  = (r_state == IDLE) && start && w_cfg_bad;
  assign w_wr_en   = (r_state == LOAD) && wr_valid;
  assign w_last_wr = w_wr_en && (r_wr_cnt == (r_npix - CNT_ONE));
  assign w_issue   = (r_state == READ) && rd_en && (w_rd_cnt < r_npix);
  assign w_ram_addr = (r_state == LOAD) ? r_wr_cnt[AW-1:0] : w_rd_addr;

  assign wr_ready  = (r_state == LOAD);
  assign busy      = (r_state != IDLE);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign finish_64 = r_finish_64;
  assign finish    = r_finish;
  assign err       = r_err;

  mem_rgb_addr_gen #(.AW(AW), .BLK(BLK)) u_addr_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_accept),
    .i_advance       (w_issue),
    .i_mode          (r_mode),
    .i_size_x        (r_size_x),
    .i_npix          (r_npix),
    .o_addr          (w_rd_addr),
    .o_cnt           (w_rd_cnt),
    .o_last_in_block (w_last_in_block),
    .o_last_in_frame (w_last_in_frame)
  );

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = LOAD;
        else          w_next_state = IDLE;
      end
      LOAD: begin
        if (w_last_wr) w_next_state = READ;
        else           w_next_state = LOAD;
      end
      READ: begin
        if (r_rd_valid && r_finish) w_next_state = IDLE;
        else                        w_next_state = READ;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, latched configuration, write counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_size_x    <= 16'd0;
      r_mode      <= MODE_RASTER;
      r_npix      <= '0;
      r_wr_cnt    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_finish_64 <= 1'b0;
      r_finish    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_err       <= w_reject;
      r_rd_valid  <= w_issue;
      r_finish_64 <= w_issue && w_last_in_block;
      r_finish    <= w_issue && w_last_in_frame;
      if (w_accept) begin
        r_size_x <= size_x;
        r_mode   <= mode;
        r_npix   <= w_prod[AW:0];
        r_wr_cnt <= '0;
      end else if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
      end
      if (w_issue) r_rd_data <= r_mem[w_ram_addr];
    end
  end

  // Frame RAM write port; LOAD and READ never overlap so the address is shared.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_ram_addr] <= wr_data;
  end

endmodule
